// File: rtl/fact_pkg.sv
// fact_pkg: register map, FSM state encoding and base address shared by the factorial bus master
package fact_pkg;

    localparam logic [7:0] FACT_BASE_DEF = 8'h20;

    localparam logic [7:0] OFF_OPERAND  = 8'd0;
    localparam logic [7:0] OFF_INTR_EN  = 8'd1;
    localparam logic [7:0] OFF_STATUS   = 8'd2;
    localparam logic [7:0] OFF_OPSTART  = 8'd3;
    localparam logic [7:0] OFF_INTR_CLR = 8'd4;
    localparam logic [7:0] OFF_RESULT_L = 8'd5;
    localparam logic [7:0] OFF_RESULT_H = 8'd6;

    // Encoding is sequential along the main path so bus states advance with state+1.
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_REQ1  = 4'd1;
    localparam logic [3:0] S_W_OP  = 4'd2;
    localparam logic [3:0] S_W_IE  = 4'd3;
    localparam logic [3:0] S_W_GO  = 4'd4;
    localparam logic [3:0] S_WAIT  = 4'd5;
    localparam logic [3:0] S_REQ2  = 4'd6;
    localparam logic [3:0] S_R_LO  = 4'd7;
    localparam logic [3:0] S_R_HI  = 4'd8;
    localparam logic [3:0] S_W_CLR = 4'd9;
    localparam logic [3:0] S_DONE  = 4'd10;
    localparam logic [3:0] S_ERR   = 4'd11;

    // Register offset addressed while in a given bus state; request states read STATUS.
    function automatic logic [7:0] state_off(logic [3:0] s);
        return (s == S_W_OP)  ? OFF_OPERAND  :
               (s == S_W_IE)  ? OFF_INTR_EN  :
               (s == S_W_GO)  ? OFF_OPSTART  :
               (s == S_R_LO)  ? OFF_RESULT_L :
               (s == S_R_HI)  ? OFF_RESULT_H :
               (s == S_W_CLR) ? OFF_INTR_CLR : OFF_STATUS;
    endfunction

endpackage

// File: rtl/fact_host_seq.sv
// fact_host_seq: bus master that programs the factorial core, waits for its interrupt and reads the result
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_n/cmd_ready   operand handshake (accepted only in IDLE)
//   res_valid/res_data/res_err  one-cycle result pulse, 64-bit result, timeout flag
//   busy                    high whenever not IDLE
//   M_req/M_wr/M_address/M_dout/M_grant/M_din   shared-bus master port
//   f_interrupt             level interrupt from the factorial core
module fact_host_seq
    import fact_pkg::*;
#(
    parameter logic [7:0] FACT_BASE   = FACT_BASE_DEF,
    parameter int         TIMEOUT_CYC = 4096,
    parameter int         TO_W        = 13
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_n,
    output logic        cmd_ready,
    output logic        res_valid,
    output logic [63:0] res_data,
    output logic        res_err,
    output logic        busy,
    output logic        M_req,
    output logic        M_wr,
    output logic [7:0]  M_address,
    output logic [31:0] M_dout,
    input  logic        M_grant,
    input  logic [31:0] M_din,
    input  logic        f_interrupt
);

    logic [3:0]      state, nxt;
    logic [31:0]     n_q;
    logic [TO_W-1:0] cnt;
    logic            accept, on_bus, nxt_req, nxt_wr;

    assign accept = cmd_valid && cmd_ready;

    // Bus states only move on while granted, so a dropped grant stalls the current access.
    assign on_bus  = (state >= S_REQ1 && state <= S_W_GO) || (state >= S_REQ2 && state <= S_W_CLR);
    assign nxt_req = (nxt >= S_REQ1 && nxt <= S_W_GO) || (nxt >= S_REQ2 && nxt <= S_W_CLR);
    assign nxt_wr  = (nxt >= S_W_OP && nxt <= S_W_GO) || nxt == S_W_CLR;

    always_comb begin
        nxt = S_IDLE;
        if (state == S_IDLE)
            nxt = accept ? S_REQ1 : S_IDLE;
        else if (on_bus)
            nxt = M_grant ? state + 4'd1 : state;
        else if (state == S_WAIT)
            nxt = f_interrupt ? S_REQ2 : (cnt == TO_W'(TIMEOUT_CYC - 1)) ? S_ERR : S_WAIT;
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            n_q       <= '0;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            res_data  <= '0;
            M_req     <= 1'b0;
            M_wr      <= 1'b0;
            M_address <= '0;
            M_dout    <= '0;
        end else begin
            state     <= nxt;
            n_q       <= accept ? cmd_n : n_q;
            cnt       <= (state == S_WAIT) ? cnt + 1'b1 : '0;
            cmd_ready <= nxt == S_IDLE;
            busy      <= nxt != S_IDLE;
            res_valid <= nxt == S_DONE || nxt == S_ERR;
            res_err   <= nxt == S_ERR;
            M_req     <= nxt_req;
            M_wr      <= nxt_wr;
            M_address <= nxt_req ? FACT_BASE + state_off(nxt) : 8'h0;
            M_dout    <= (nxt == S_W_OP) ? n_q : nxt_wr ? 32'h1 : 32'h0;
            if (M_grant && state == S_R_LO)
                res_data[31:0] <= M_din;
            if (M_grant && state == S_R_HI)
                res_data[63:32] <= M_din;
        end
    end

endmodule
